can_bit_destuffer: RTL

Parametrised CAN bit-destuffing and stuff-rule checking block for the receive path. It sits between the bit-timing sampler and the frame decoder. On each sample-point strobe it:
- forwards data bits to the decoder;
- silently removes dynamic stuff bits;
- flags any run of more than RUN_LEN equal bits inside the stuffed region.

Generalised over run length, counter width and error-flag mode.

---
 rtl/can_stuff_pkg.sv | 14 +
 rtl/can_stuff_cnt.sv | 37 +++
 rtl/can_bit_destuffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/can_stuff_pkg.sv
// Shared types and constants for the CAN receive-path bit destuffer.
package can_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPECT = 2'd2,
        ERROR  = 2'd3
    } stuff_state_t;

    localparam int CAN_RUN_LEN_CLASSIC = 5;
    localparam int STUFF_CNT_W         = 3;

endpackage

// File: rtl/can_stuff_cnt.sv
// Modulo-8 count of removed stuff bits, restarted at the beginning of every stuffed region.
module can_stuff_cnt
    import can_stuff_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stuff_en,
    input  logic                   stuff_drop,
    output logic [STUFF_CNT_W-1:0] stuff_cnt
);

    logic                   stuff_en_q, stuff_en_d;
    logic [STUFF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stuff_en_d = stuff_en;
        cnt_d      = cnt_q;
        if (stuff_en && !stuff_en_q) begin
            cnt_d = '0;
        end else if (stuff_drop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stuff_en_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            stuff_en_q <= stuff_en_d;
            cnt_q      <= cnt_d;
        end
    end

    assign stuff_cnt = cnt_q;

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer and stuff-rule checker; all outputs registered, one clk after sample_en.
// Define CAN_STUFF_CNT_EN to build the modulo-8 stuff-bit counter; otherwise stuff_cnt is 0.
module can_bit_destuffer
    import can_stuff_pkg::*;
#(
    parameter int RUN_LEN    = CAN_RUN_LEN_CLASSIC,
    parameter int CNT_W      = 4,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic                   rx_bit,
    input  logic                   stuff_en,
    output logic                   data_bit,
    output logic                   data_valid,
    output logic                   stuff_drop,
    output logic                   stuff_err,
    output logic [CNT_W-1:0]       run_cnt,
    output logic [STUFF_CNT_W-1:0] stuff_cnt
);

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    stuff_state_t     state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             data_bit_q, data_bit_d;
    logic             data_valid_q, data_valid_d;
    logic             stuff_drop_q, stuff_drop_d;
    logic             stuff_err_q, stuff_err_d;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_cnt_d    = run_cnt_q;
        data_bit_d   = data_bit_q;
        data_valid_d = 1'b0;
        stuff_drop_d = 1'b0;
        stuff_err_d  = ERR_STICKY ? stuff_err_q : 1'b0;

        // Leaving the stuffed region overrides every state, including a pending stuff bit.
        if (!stuff_en) begin
            state_d     = IDLE;
            run_cnt_d   = '0;
            stuff_err_d = 1'b0;
            if (sample_en) begin
                data_bit_d   = rx_bit;
                data_valid_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_en) begin
                        data_bit_d   = rx_bit;
                        data_valid_d = 1'b1;
                        prev_d       = rx_bit;
                        run_cnt_d    = ONE_C;
                        state_d      = COUNT;
                    end
                end
                COUNT: begin
                    if (sample_en) begin
                        data_bit_d   = rx_bit;
                        data_valid_d = 1'b1;
                        if (rx_bit == prev_q) begin
                            run_cnt_d = run_cnt_q + ONE_C;
                            if (run_cnt_q + ONE_C == RUN_LEN_C) begin
                                state_d = EXPECT;
                            end
                        end else begin
                            run_cnt_d = ONE_C;
                            prev_d    = rx_bit;
                        end
                    end
                end
                EXPECT: begin
                    if (sample_en) begin
                        if (rx_bit != prev_q) begin
                            stuff_drop_d = 1'b1;
                            prev_d       = rx_bit;
                            run_cnt_d    = ONE_C;
                            state_d      = COUNT;
                        end else begin
                            stuff_err_d = 1'b1;
                            state_d     = ERROR;
                        end
                    end
                end
                ERROR: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= 1'b0;
            run_cnt_q    <= '0;
            data_bit_q   <= 1'b0;
            data_valid_q <= 1'b0;
            stuff_drop_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_cnt_q    <= run_cnt_d;
            data_bit_q   <= data_bit_d;
            data_valid_q <= data_valid_d;
            stuff_drop_q <= stuff_drop_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign data_bit   = data_bit_q;
    assign data_valid = data_valid_q;
    assign stuff_drop = stuff_drop_q;
    assign stuff_err  = stuff_err_q;
    assign run_cnt    = run_cnt_q;

`ifdef CAN_STUFF_CNT_EN
    // Fed from the next-state drop so the count moves together with stuff_drop.
    can_stuff_cnt u_stuff_cnt (
        .clk        (clk),
        .reset      (reset),
        .stuff_en   (stuff_en),
        .stuff_drop (stuff_drop_d),
        .stuff_cnt  (stuff_cnt)
    );
`else
    assign stuff_cnt = '0;
`endif

endmodule
